src_control_unit: RTL and testbench

- Hardwired control unit for the single-bus SRC-style CPU.
- Steps fetch and execute through step counter T0..T7 and drives all bus-driver, register-load and ALU strobes, including regfile field selects (gra/grb/grc) and rin/rout/baout.
- Holds the branch-condition flag (CON) and runs the memory read/write handshake.
- Sits beside the datapath; its only datapath inputs are the latched IR and the shared bus.

---
 rtl/src_ctrl_pkg.sv | 27 ++
 rtl/src_branch_cond.sv | 17 +
 rtl/src_control_unit.sv | 111 +++++++++++
 tb/tb_src_control_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/src_ctrl_pkg.sv
// src_ctrl_pkg: opcode, step, ALU-operation and branch-condition encodings shared by the SRC control unit
package src_ctrl_pkg;
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_LD   = 5'd1,
    OP_ST   = 5'd3,
    OP_LA   = 5'd5,
    OP_BR   = 5'd8,
    OP_ADD  = 5'd12,
    OP_ADDI = 5'd13,
    OP_SUB  = 5'd14,
    OP_AND  = 5'd20,
    OP_OR   = 5'd22,
    OP_STOP = 5'd31
  } op_e;
  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_e;
  typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_INC4} alu_op_e;
  localparam logic [2:0] CC_NEVER   = 3'd0;
  localparam logic [2:0] CC_ALWAYS  = 3'd1;
  localparam logic [2:0] CC_ZERO    = 3'd2;
  localparam logic [2:0] CC_NONZERO = 3'd3;
  localparam logic [2:0] CC_GE      = 3'd4;
  localparam logic [2:0] CC_LT      = 3'd5;
  function automatic logic is_legal(input logic [4:0] op);
    return op inside {OP_NOP, OP_LD, OP_ST, OP_LA, OP_BR, OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_STOP};
  endfunction
endpackage

// File: rtl/src_branch_cond.sv
// src_branch_cond: combinational branch-condition evaluation of the bus against the IR condition field
module src_branch_cond
  import src_ctrl_pkg::*;
#(
  parameter int w = 32,
  parameter int COND_MSB = 2
) (
  input  logic [w-1:0]      bus,
  input  logic [COND_MSB:0] cond,
  output logic              con
);
  assign con = cond == CC_ALWAYS ||
               (cond == CC_ZERO && bus == '0) ||
               (cond == CC_NONZERO && bus != '0) ||
               (cond == CC_GE && !bus[w-1]) ||
               (cond == CC_LT && bus[w-1]);
endmodule

// File: rtl/src_control_unit.sv
// src_control_unit: hardwired T0..T7 sequencer and strobe decoder for the single-bus SRC CPU
module src_control_unit
  import src_ctrl_pkg::*;
#(
  parameter int w = 32,
  parameter int OP_MSB = 31,
  parameter int OP_LSB = 27,
  parameter int COND_MSB = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [w-1:0] ir,
  input  logic [w-1:0] bus,
  input  logic         mem_done,
  output logic         pc_out,
  output logic         pc_in,
  output logic         ma_in,
  output logic         md_out,
  output logic         md_bus_in,
  output logic         ir_in,
  output logic         a_in,
  output logic         c_in,
  output logic         c_out,
  output logic         c2_out,
  output logic [2:0]   alu_op,
  output logic         gra,
  output logic         grb,
  output logic         grc,
  output logic         rin,
  output logic         rout,
  output logic         baout,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic         halted,
  output logic         illegal
);
  step_e step;
  alu_op_e alu, rr_alu;
  logic [4:0] op;
  logic con, con_now, halted_r, illegal_r, active, legal, halt_op, rr, wait_step, end_step;
  logic unused_ir;
  assign unused_ir = ^ir;
  assign op = ir[OP_MSB:OP_LSB];
  assign legal = is_legal(op);
  assign halt_op = op == OP_STOP || !legal;
  assign rr = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
  assign rr_alu = op == OP_SUB ? ALU_SUB : op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_ADD;
  assign wait_step = step == T1 || (step == T6 && op == OP_LD) || (step == T7 && op == OP_ST);
  assign end_step = (step == T3 && op == OP_NOP) || (step == T4 && op == OP_BR) ||
                    (step == T5 && (rr || op == OP_ADDI || op == OP_LA)) || step == T7;
  assign active = !rst && !halted_r;
  assign halted = !rst && (halted_r || (step == T3 && halt_op));
  assign illegal = !rst && (illegal_r || (step == T3 && !legal));
  assign alu_op = alu;
  src_branch_cond #(.w(w), .COND_MSB(COND_MSB)) u_cond (
    .bus(bus),
    .cond(ir[COND_MSB:0]),
    .con(con_now)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      step <= T0;
      con <= 1'b0;
      halted_r <= 1'b0;
      illegal_r <= 1'b0;
    end else if (!halted_r) begin
      if (step == T3 && halt_op) begin
        halted_r <= 1'b1;
        illegal_r <= !legal;
      end else if (!wait_step || mem_done) begin
        step <= end_step ? T0 : step_e'(step + 3'd1);
      end
      if (step == T3 && op == OP_BR) con <= con_now;
    end
  end
  always_comb begin
    {pc_out, pc_in, ma_in, md_out, md_bus_in, ir_in, a_in, c_in, c_out, c2_out} = '0;
    {gra, grb, grc, rin, rout, baout, mem_rd, mem_wr} = '0;
    alu = ALU_PASS;
    if (active) begin
      case (step)
        T0: {pc_out, ma_in, c_in, alu} = {3'b111, ALU_INC4};
        T1: {c_out, pc_in, mem_rd} = 3'b111;
        T2: {md_out, ir_in} = 2'b11;
        T3: begin
          if (rr || op == OP_ADDI) {grb, rout, a_in} = 3'b111;
          else if (op inside {OP_LD, OP_ST, OP_LA}) {grb, baout, a_in} = 3'b111;
          else if (op == OP_BR) {grc, rout} = 2'b11;
        end
        T4: begin
          if (rr) {grc, rout, c_in, alu} = {3'b111, rr_alu};
          else if (op inside {OP_ADDI, OP_LD, OP_ST, OP_LA}) {c2_out, c_in, alu} = {2'b11, ALU_ADD};
          else if (op == OP_BR) {grb, rout, pc_in} = {2'b11, con};
        end
        T5: begin
          if (rr || op == OP_ADDI || op == OP_LA) {c_out, gra, rin} = 3'b111;
          else if (op == OP_LD || op == OP_ST) {c_out, ma_in} = 2'b11;
        end
        T6: begin
          if (op == OP_LD) mem_rd = 1'b1;
          else if (op == OP_ST) {gra, rout, md_bus_in} = 3'b111;
        end
        T7: begin
          if (op == OP_LD) {md_out, gra, rin} = 3'b111;
          else if (op == OP_ST) mem_wr = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_src_control_unit.sv
// tb_src_control_unit: randomized scoreboard bench comparing every cycle's strobes against an instruction-level model
module tb_src_control_unit;
  localparam int PC_OUT = 22, PC_IN = 21, MA_IN = 20, MD_OUT = 19, MD_BUS_IN = 18, IR_IN = 17;
  localparam int A_IN = 16, C_IN = 15, C_OUT = 14, C2_OUT = 13, ALU = 10;
  localparam int GRA = 9, GRB = 8, GRC = 7, RIN = 6, ROUT = 5, BAOUT = 4;
  localparam int MEM_RD = 3, MEM_WR = 2, HALTED = 1, ILLEGAL = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_done = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] bus = '0;
  logic pc_out, pc_in, ma_in, md_out, md_bus_in, ir_in, a_in, c_in, c_out, c2_out;
  logic gra, grb, grc, rin, rout, baout, mem_rd, mem_wr, halted, illegal;
  logic [2:0] alu_op;
  logic [22:0] dv;
  logic [22:0] expq[$];
  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  bit mcon = 1'b0;
  always #5 clk = ~clk;
  src_control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .bus(bus), .mem_done(mem_done),
    .pc_out(pc_out), .pc_in(pc_in), .ma_in(ma_in), .md_out(md_out), .md_bus_in(md_bus_in),
    .ir_in(ir_in), .a_in(a_in), .c_in(c_in), .c_out(c_out), .c2_out(c2_out), .alu_op(alu_op),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
  );
  assign dv = {pc_out, pc_in, ma_in, md_out, md_bus_in, ir_in, a_in, c_in, c_out, c2_out, alu_op,
               gra, grb, grc, rin, rout, baout, mem_rd, mem_wr, halted, illegal};
  function automatic logic [22:0] b(input int i);
    return 23'(1) << i;
  endfunction
  function automatic logic [22:0] f(input logic [2:0] a);
    return 23'(a) << ALU;
  endfunction
  function automatic bit legal(input logic [4:0] op);
    return op inside {5'd0, 5'd1, 5'd3, 5'd5, 5'd8, 5'd12, 5'd13, 5'd14, 5'd20, 5'd22, 5'd31};
  endfunction
  function automatic bit cond_of(input logic [2:0] c, input logic [31:0] v);
    case (c)
      3'd1: return 1'b1;
      3'd2: return v == 0;
      3'd3: return v != 0;
      3'd4: return $signed(v) >= 0;
      3'd5: return $signed(v) < 0;
      default: return 1'b0;
    endcase
  endfunction
  function automatic int nsteps(input logic [4:0] op);
    if (op == 5'd0) return 4;
    if (op == 5'd8) return 5;
    if (op == 5'd1 || op == 5'd3) return 8;
    return 6;
  endfunction
  function automatic logic [22:0] expv(input logic [4:0] op, input int k, input bit c);
    bit rr = op == 5'd12 || op == 5'd14 || op == 5'd20 || op == 5'd22;
    bit ls = op == 5'd1 || op == 5'd3 || op == 5'd5;
    logic [2:0] a = op == 5'd14 ? 3'd2 : op == 5'd20 ? 3'd3 : op == 5'd22 ? 3'd4 : 3'd1;
    logic [22:0] v = '0;
    case (k)
      0: v = b(PC_OUT) | b(MA_IN) | b(C_IN) | f(3'd5);
      1: v = b(C_OUT) | b(PC_IN) | b(MEM_RD);
      2: v = b(MD_OUT) | b(IR_IN);
      3: v = (rr || op == 5'd13) ? b(GRB) | b(ROUT) | b(A_IN) :
             ls ? b(GRB) | b(BAOUT) | b(A_IN) :
             op == 5'd8 ? b(GRC) | b(ROUT) : '0;
      4: v = rr ? b(GRC) | b(ROUT) | b(C_IN) | f(a) :
             (op == 5'd13 || ls) ? b(C2_OUT) | b(C_IN) | f(3'd1) :
             op == 5'd8 ? b(GRB) | b(ROUT) | (c ? b(PC_IN) : '0) : '0;
      5: v = (rr || op == 5'd13 || op == 5'd5) ? b(C_OUT) | b(GRA) | b(RIN) :
             (op == 5'd1 || op == 5'd3) ? b(C_OUT) | b(MA_IN) : '0;
      6: v = op == 5'd1 ? b(MEM_RD) : op == 5'd3 ? b(GRA) | b(ROUT) | b(MD_BUS_IN) : '0;
      7: v = op == 5'd1 ? b(MD_OUT) | b(GRA) | b(RIN) : op == 5'd3 ? b(MEM_WR) : '0;
      default: v = '0;
    endcase
    return v;
  endfunction
  task automatic cyc(input logic md, input logic [31:0] bv, input logic [31:0] instr, input logic r,
                     input logic [22:0] e);
    mem_done = md;
    bus = bv;
    ir = instr;
    rst = r;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [31:0] instr, input logic [31:0] bv, input int wlo, input int whi);
    logic [4:0] op = instr[31:27];
    int n = nsteps(op);
    bit c = (op == 5'd8) ? cond_of(instr[2:0], bv) : mcon;
    for (int k = 0; k < n; k++) begin
      bit wt = k == 1 || (k == 6 && op == 5'd1) || (k == 7 && op == 5'd3);
      int ws = wt ? int'($urandom_range(whi, wlo)) : 0;
      logic [22:0] e = expv(op, k, c);
      for (int j = 0; j < ws; j++) cyc(1'b0, $urandom, instr, 1'b0, e);
      cyc(wt ? 1'b1 : 1'($urandom), k == 3 ? bv : $urandom, instr, 1'b0, e);
    end
    mcon = c;
  endtask
  task automatic run_halt(input logic [4:0] op, input int n);
    logic [31:0] instr = {op, 27'($urandom)};
    logic [22:0] h = b(HALTED) | (legal(op) ? '0 : b(ILLEGAL));
    for (int k = 0; k < 3; k++) cyc(k == 1 ? 1'b1 : 1'($urandom), $urandom, instr, 1'b0, expv(op, k, mcon));
    for (int j = 0; j < n; j++) cyc(1'($urandom), $urandom, instr, 1'b0, h);
    cyc(1'($urandom), $urandom, instr, 1'b1, '0);
    mcon = 1'b0;
  endtask
  task automatic run_ld_reset();
    logic [31:0] instr = {5'd1, 27'($urandom)};
    for (int k = 0; k < 6; k++) cyc(k == 1 ? 1'b1 : 1'($urandom), $urandom, instr, 1'b0, expv(5'd1, k, mcon));
    cyc(1'b0, $urandom, instr, 1'b0, expv(5'd1, 6, mcon));
    cyc(1'b0, $urandom, instr, 1'b0, expv(5'd1, 6, mcon));
    cyc(1'b0, $urandom, instr, 1'b1, '0);
    checks++;
    if (mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL expired wait: mem_rd=%b after rst during ld T6 wait", mem_rd);
    end
    mcon = 1'b0;
  endtask
  always @(negedge clk) begin
    logic [22:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (dv !== e) begin
        failures++;
        $display("FAIL strobes cycle=%0d got=%06h want=%06h", cyc_n, dv, e);
      end
      cyc_n++;
    end
  end
  initial begin
    logic [4:0] ops[10] = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd8, 5'd12, 5'd13, 5'd14, 5'd20, 5'd22};
    logic [31:0] bv;
    logic [4:0] op;
    @(posedge clk);
    #1;
    cyc(1'b1, '0, '0, 1'b1, '0);
    checks++;
    if (dv !== '0) begin
      failures++;
      $display("FAIL reset state: got=%06h want=000000", dv);
    end
    run(32'h6088_C000, $urandom, 0, 0);
    run(32'h0904_0008, $urandom, 3, 3);
    run(32'h4000_0002, 32'd0, 0, 1);
    run(32'h4000_0002, 32'd5, 0, 1);
    run(32'h187E_0000, $urandom, 1, 3);
    run_halt(5'd31, 20);
    run_ld_reset();
    run_halt(5'd2, 5);
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(9, 0)];
      case ($urandom_range(2, 0))
        0: bv = '0;
        1: bv = $urandom & 32'h7FFF_FFFF;
        default: bv = $urandom | 32'h8000_0000;
      endcase
      run({op, 27'($urandom)}, bv, 0, 3);
    end
    run_halt(5'd31, 4);
    run_halt(5'd7, 4);
    cyc(1'b0, '0, '0, 1'b0, expv(5'd0, 0, 1'b0));
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
